// File: rtl/result_tx_queue.sv
// result_tx_queue
//   Buffers found-share results ({job_id, nonce}) from the hash cores and feeds them to the
//   UART output FSM one byte at a time. The output FSM watches o_avail, pulses i_load to
//   move one 8-byte result into the shift register, then pulses i_shift once per byte sent.
//   Bytes leave least-significant first, so the nonce goes out before the job id.
//
//   Optional feature, enabled by defining RESULT_DEDUP_EN:
//     A push whose data equals the last accepted push is dropped silently. It is not
//     written and it does not set overflow. Without the macro every push follows the
//     normal full rules.
module result_tx_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  logic [63:0]   i_push_data,
    output logic          o_full,
    output logic          o_overflow,
    output logic          o_avail,
    input  logic          i_load,
    input  logic          i_shift,
    output logic [7:0]    o_tx_byte,
    output logic [3:0]    o_bytes_left,
    output logic [AW:0]   o_count
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [63:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [63:0]   r_shift_reg;
    logic [3:0]    r_bytes_left;
    logic          r_overflow;

    logic          w_full;
    logic          w_avail;
    logic          w_pop;
    logic          w_dup;
    logic          w_push_ok;
    logic          w_push_drop;

    assign w_full  = (r_count == FULL_CNT);
    assign w_avail = (r_count != '0);

    // A load pops the head only when something is queued. When the FIFO is full,
    // that pop frees the slot that a push in the same cycle needs.
    assign w_pop       = i_load && w_avail;
    assign w_push_ok   = i_push && !w_dup && (!w_full || w_pop);
    assign w_push_drop = i_push && !w_dup && w_full && !w_pop;

`ifdef RESULT_DEDUP_EN
    logic [63:0] r_last_acc;
    logic        r_last_vld;

    // The duplicate check happens before the full check, so a repeat never counts as an overflow.
    assign w_dup = r_last_vld && (i_push_data == r_last_acc);

    // Remember the most recently accepted result.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last_acc <= '0;
            r_last_vld <= 1'b0;
        end else if (w_push_ok) begin
            r_last_acc <= i_push_data;
            r_last_vld <= 1'b1;
        end
    end
`else
    assign w_dup = 1'b0;
`endif

    // FIFO storage: an accepted push is written at the write pointer.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push_ok && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push_ok) begin
                r_count <= r_count - 1'b1;
            end
            if (w_push_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Output shift register. A load wins over a shift and abandons any unsent bytes.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_shift_reg  <= '0;
            r_bytes_left <= '0;
        end else if (w_pop) begin
            r_shift_reg  <= r_mem[r_rd_ptr];
            r_bytes_left <= 4'd8;
        end else if (i_shift && (r_bytes_left != 4'd0)) begin
            r_shift_reg  <= r_shift_reg >> 8;
            r_bytes_left <= r_bytes_left - 4'd1;
        end
    end

    assign o_full       = w_full;
    assign o_avail      = w_avail;
    assign o_overflow   = r_overflow;
    assign o_count      = r_count;
    assign o_tx_byte    = r_shift_reg[7:0];
    assign o_bytes_left = r_bytes_left;

endmodule

// File: tb/tb_result_tx_queue.sv
// tb_result_tx_queue
//   Self-checking bench for result_tx_queue (DEPTH=4). The queue of accepted results is
//   the scoreboard: entries are pushed when a push should be accepted, and popped when a
//   load should move one into the shift register. The table of vectors covers the
//   basic serialization sequence, and hand-written sequences cover the corner cases.
module tb_result_tx_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          push = 1'b0;
    logic [63:0]   push_data = '0;
    logic          load = 1'b0;
    logic          shift = 1'b0;
    logic          full;
    logic          overflow;
    logic          avail;
    logic [7:0]    tx_byte;
    logic [3:0]    bytes_left;
    logic [AW:0]   count;

    int errors = 0;
    int checks = 0;

    logic [63:0] sb_q[$];
    logic [63:0] m_sr;
    int          m_bl;
    bit          m_ovf;
    logic [63:0] m_last;
    bit          m_last_v;

    always #5 clk = ~clk;

    result_tx_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_push       (push),
        .i_push_data  (push_data),
        .o_full       (full),
        .o_overflow   (overflow),
        .o_avail      (avail),
        .i_load       (load),
        .i_shift      (shift),
        .o_tx_byte    (tx_byte),
        .o_bytes_left (bytes_left),
        .o_count      (count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        sb_q.delete();
        m_sr     = '0;
        m_bl     = 0;
        m_ovf    = 1'b0;
        m_last   = '0;
        m_last_v = 1'b0;
    endtask

    // Expected effect of one clock edge with the given inputs, taken from the pre-edge state.
    task automatic model_update(input bit p, input logic [63:0] d, input bit l, input bit s);
        bit is_full, pop, dup, acc;
        is_full = (sb_q.size() == DEPTH);
        pop     = l && (sb_q.size() != 0);
        dup     = 1'b0;
`ifdef RESULT_DEDUP_EN
        dup     = m_last_v && (d == m_last);
`endif
        acc = p && !dup && (!is_full || pop);
        if (p && !dup && is_full && !pop) m_ovf = 1'b1;
        if (pop) begin
            m_sr = sb_q.pop_front();
            m_bl = 8;
        end else if (s && m_bl != 0) begin
            m_sr = m_sr >> 8;
            m_bl = m_bl - 1;
        end
        if (acc) begin
            sb_q.push_back(d);
            m_last   = d;
            m_last_v = 1'b1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"},      64'(count),      64'(sb_q.size()));
        chk({tag, ".full"},       64'(full),       64'(sb_q.size() == DEPTH));
        chk({tag, ".avail"},      64'(avail),      64'(sb_q.size() != 0));
        chk({tag, ".overflow"},   64'(overflow),   64'(m_ovf));
        chk({tag, ".tx_byte"},    64'(tx_byte),    64'(m_sr[7:0]));
        chk({tag, ".bytes_left"}, 64'(bytes_left), 64'(m_bl));
    endtask

    task automatic step(input string tag, input bit p, input logic [63:0] d, input bit l, input bit s);
        @(negedge clk);
        push = p; push_data = d; load = l; shift = s;
        model_update(p, d, l, s);
        @(posedge clk);
        #1;
        push = 1'b0; load = 1'b0; shift = 1'b0;
        check_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        push = 1'b0; load = 1'b0; shift = 1'b0;
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        bit          push;
        logic [63:0] data;
        bit          load;
        bit          shift;
        logic [7:0]  exp_tx;
        logic [3:0]  exp_bl;
        logic [2:0]  exp_cnt;
    } vec_t;

    vec_t vecs[11];

    localparam logic [63:0] D1 = 64'h0000_0007_DEAD_BEEF;

    initial begin
        vecs[0]  = '{1'b1, D1,  1'b0, 1'b0, 8'h00, 4'd0, 3'd1};
        vecs[1]  = '{1'b0, '0,  1'b1, 1'b0, 8'hEF, 4'd8, 3'd0};
        vecs[2]  = '{1'b0, '0,  1'b0, 1'b1, 8'hBE, 4'd7, 3'd0};
        vecs[3]  = '{1'b0, '0,  1'b0, 1'b1, 8'hAD, 4'd6, 3'd0};
        vecs[4]  = '{1'b0, '0,  1'b0, 1'b1, 8'hDE, 4'd5, 3'd0};
        vecs[5]  = '{1'b0, '0,  1'b0, 1'b1, 8'h07, 4'd4, 3'd0};
        vecs[6]  = '{1'b0, '0,  1'b0, 1'b1, 8'h00, 4'd3, 3'd0};
        vecs[7]  = '{1'b0, '0,  1'b0, 1'b1, 8'h00, 4'd2, 3'd0};
        vecs[8]  = '{1'b0, '0,  1'b0, 1'b1, 8'h00, 4'd1, 3'd0};
        vecs[9]  = '{1'b0, '0,  1'b0, 1'b1, 8'h00, 4'd0, 3'd0};
        vecs[10] = '{1'b0, '0,  1'b0, 1'b1, 8'h00, 4'd0, 3'd0};

        model_clear();
        #1;
        check_all("rst_async");
        do_reset();
        #1;
        check_all("reset");

        // Test 1: little-endian serialization of a single result
        for (int i = 0; i < 11; i++) begin
            step($sformatf("t1[%0d]", i), vecs[i].push, vecs[i].data, vecs[i].load, vecs[i].shift);
            chk($sformatf("t1[%0d].tbl_tx", i),  64'(tx_byte),    64'(vecs[i].exp_tx));
            chk($sformatf("t1[%0d].tbl_bl", i),  64'(bytes_left), 64'(vecs[i].exp_bl));
            chk($sformatf("t1[%0d].tbl_cnt", i), 64'(count),      64'(vecs[i].exp_cnt));
        end

        // Test 2: overfill, then drain in order
        do_reset();
        for (int i = 0; i < 5; i++)
            step($sformatf("t2.push%0d", i), 1'b1, 64'hA000_0000_0000_0010 + 64'(i * 17), 1'b0, 1'b0);
        chk("t2.count4", 64'(count), 64'd4);
        chk("t2.full",   64'(full), 64'd1);
        chk("t2.ovf",    64'(overflow), 64'd1);
        for (int i = 0; i < 4; i++) begin
            step($sformatf("t2.load%0d", i), 1'b0, '0, 1'b1, 1'b0);
            chk($sformatf("t2.order%0d", i), 64'(tx_byte), 64'(8'h10 + 8'(i * 17)));
        end
        chk("t2.avail_end", 64'(avail), 64'd0);

        // Test 3: push and load together while full, then drain across the wrap
        do_reset();
        for (int i = 0; i < 4; i++)
            step($sformatf("t3.push%0d", i), 1'b1, 64'h0000_0B00_0000_3000 + 64'(i * 8'h11), 1'b0, 1'b0);
        step("t3.pushload", 1'b1, 64'h1234_5678_9ABC_DE55, 1'b1, 1'b0);
        chk("t3.count", 64'(count), 64'd4);
        chk("t3.ovf",   64'(overflow), 64'd0);
        for (int i = 0; i < 4; i++) begin
            step($sformatf("t3.load%0d", i), 1'b0, '0, 1'b1, 1'b0);
            step($sformatf("t3.shift%0d", i), 1'b0, '0, 1'b0, 1'b1);
        end
        chk("t3.last_byte1", 64'(tx_byte), 64'hDE);

        // Test 4: load on empty ignored; load beats shift in the same cycle
        do_reset();
        step("t4.push", 1'b1, 64'h0102_0304_0506_0708, 1'b0, 1'b0);
        step("t4.load", 1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step($sformatf("t4.sh%0d", i), 1'b0, '0, 1'b0, 1'b1);
        step("t4.empty_load", 1'b0, '0, 1'b1, 1'b0);
        chk("t4.bl_kept", 64'(bytes_left), 64'd5);
        chk("t4.tx_kept", 64'(tx_byte), 64'h05);
        step("t4.push2", 1'b1, 64'hFFEE_DDCC_BBAA_9988, 1'b0, 1'b0);
        step("t4.load_shift", 1'b0, '0, 1'b1, 1'b1);
        chk("t4.bl8", 64'(bytes_left), 64'd8);
        chk("t4.tx_new", 64'(tx_byte), 64'h88);

        // Test 5: asynchronous reset in the middle of a frame
        do_reset();
        for (int i = 0; i < 5; i++)
            step($sformatf("t5.push%0d", i), 1'b1, 64'hC0C0_0000_0000_0001 + 64'(i), 1'b0, 1'b0);
        step("t5.load", 1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step($sformatf("t5.sh%0d", i), 1'b0, '0, 1'b0, 1'b1);
        chk("t5.pre_cnt", 64'(count), 64'd3);
        chk("t5.pre_bl",  64'(bytes_left), 64'd4);
        #2;
        rst = 1'b1;
        model_clear();
        #1;
        check_all("t5.in_rst");
        @(negedge clk);
        rst = 1'b0;
        step("t5.after", 1'b0, '0, 1'b0, 1'b1);
        step("t5.after_load", 1'b0, '0, 1'b1, 1'b0);

        // Test 6: repeated result
        do_reset();
        step("t6.a", 1'b1, 64'h0000_0001_0000_AAAA, 1'b0, 1'b0);
        step("t6.a2", 1'b1, 64'h0000_0001_0000_AAAA, 1'b0, 1'b0);
        step("t6.b", 1'b1, 64'h0000_0001_0000_BBBB, 1'b0, 1'b0);
`ifdef RESULT_DEDUP_EN
        chk("t6.count", 64'(count), 64'd2);
`else
        chk("t6.count", 64'(count), 64'd3);
`endif
        chk("t6.ovf", 64'(overflow), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
